// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter that lets NREQ requesters share one downstream FIFO write port.
// The owner keeps the grant for up to MAX_BURST accepted words, and the grant is held while the FIFO is full.
module fifo_wr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*WIDTH-1:0]    req_data,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          req_ack,
  input  logic                     fifo_full,
  output logic                     fifo_wr_en,
  output logic [WIDTH-1:0]         fifo_data,
  output logic [$clog2(NREQ)-1:0]  owner,
  output logic                     busy
);

  localparam int IW = $clog2(NREQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t          state, state_d;
  logic [NREQ-1:0] gnt_d;
  logic [IW-1:0]   owner_d, rr_ptr, rr_ptr_d, next_ptr, search_ptr, win_idx;
  logic [BW-1:0]   burst_cnt, burst_cnt_d;
  logic [IW:0]     scan;
  logic            win_found, accept, rel;

  assign req_ack    = gnt & req & {NREQ{~fifo_full}};
  assign fifo_wr_en = |req_ack;
  assign accept     = fifo_wr_en;
  assign fifo_data  = req_data[int'(owner)*WIDTH +: WIDTH];
  assign busy       = (state == OWN);

  assign next_ptr   = (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
  assign rel        = (state == OWN) &&
                      ((accept && burst_cnt == BW'(MAX_BURST - 1)) || !req[owner]);
  // On release the search starts after the releasing owner so it gets lowest priority.
  assign search_ptr = rel ? next_ptr : rr_ptr;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan      = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan = {1'b0, search_ptr} + (IW+1)'(k);
      if (scan >= (IW+1)'(NREQ)) scan = scan - (IW+1)'(NREQ);
      if (!win_found && req[scan[IW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan[IW-1:0];
      end
    end
  end

  // NOTE: every output of this block gets a default first so no path leaves a latch behind.
  always_comb begin
    state_d     = state;
    gnt_d       = gnt;
    owner_d     = owner;
    rr_ptr_d    = rr_ptr;
    burst_cnt_d = burst_cnt;
    unique case (state)
      IDLE: begin
        if (win_found) begin
          state_d        = OWN;
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          owner_d        = win_idx;
          burst_cnt_d    = '0;
        end
      end
      OWN: begin
        if (rel) begin
          rr_ptr_d    = next_ptr;
          burst_cnt_d = '0;
          if (win_found) begin
            gnt_d          = '0;
            gnt_d[win_idx] = 1'b1;
            owner_d        = win_idx;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            owner_d = '0;
          end
        end else if (accept) begin
          burst_cnt_d = burst_cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      gnt       <= '0;
      owner     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_d;
      gnt       <= gnt_d;
      owner     <= owner_d;
      rr_ptr    <= rr_ptr_d;
      burst_cnt <= burst_cnt_d;
    end
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the data word width in bits.
REQ-002 The block SHALL have parameter NREQ, default 4, meaning the number of requesters (2..16).
REQ-003 The block SHALL have parameter MAX_BURST, default 4, meaning the maximum words accepted per grant (1..255).
REQ-004 The block SHALL have port clk, input, 1, meaning the clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rstn, input, 1, meaning the reset: asynchronous, active-low.
REQ-006 The block SHALL have port req, input, NREQ, meaning bit i is high while requester i has a word to write.
REQ-007 The block SHALL have port req_data, input, NREQ*WIDTH, meaning the word of requester i on bits [i*WIDTH +: WIDTH].
REQ-008 The block SHALL have port gnt, output, NREQ, meaning a registered one-hot grant, or all-zero when idle.
REQ-009 The block SHALL have port req_ack, output, NREQ, meaning bit i is high when requester i's word is accepted this cycle.
REQ-010 The block SHALL have port fifo_full, input, 1, meaning the full flag of the downstream FIFO.
REQ-011 The block SHALL have port fifo_wr_en, output, 1, meaning the write enable to the downstream FIFO.
REQ-012 The block SHALL have port fifo_data, output, WIDTH, meaning the write data to the downstream FIFO.
REQ-013 The block SHALL have port owner, output, $clog2(NREQ), meaning the index of the granted requester, 0 when idle.
REQ-014 The block SHALL have port busy, output, 1, meaning high when state is OWN.

Function
REQ-015 States SHALL be exactly IDLE (gnt==0) and OWN (gnt one-hot); state, gnt, owner, rr_ptr and burst_cnt are registers.
REQ-016 req_ack[i] SHALL equal gnt[i] & req[i] & !fifo_full, combinationally, with no registered stage.
REQ-017 fifo_wr_en SHALL equal the OR of req_ack bits, and fifo_data SHALL equal req_data slice [owner] (don't-care when fifo_wr_en is low).
REQ-018 Winner selection SHALL pick the first set req bit searching from index rr_ptr upward, modulo NREQ.
REQ-019 IDLE with any req high SHALL move to OWN next cycle, with gnt/owner set to the winner and burst_cnt=0; arbitration latency SHALL be exactly 1 cycle.
REQ-020 IDLE with req==0 SHALL remain in IDLE.
REQ-021 In OWN, each accepted word SHALL increment burst_cnt (width $clog2(MAX_BURST+1)).
REQ-022 Release SHALL occur on (a) an accept while burst_cnt==MAX_BURST-1, or (b) req[owner] low in that cycle.
REQ-023 On release, rr_ptr SHALL become (owner+1) mod NREQ, so the releasing requester has lowest priority next.
REQ-024 On release, the next winner SHALL be selected from the current req using the updated rr_ptr.
REQ-025 On release, if a winner exists, the block SHALL hand off directly to OWN with the new gnt next cycle, with no idle bubble and burst_cnt=0.
REQ-026 On release, if no winner exists, the block SHALL go to IDLE.
REQ-027 While fifo_full is high, no word SHALL be accepted, burst_cnt SHALL hold, and the grant SHALL be held with no timeout.
REQ-028 Changes of req for non-owners SHALL NOT affect gnt while in OWN.
REQ-029 The same requester MAY be re-granted after a release only when it is the sole requester.
REQ-030 With MAX_BURST=1, every accept SHALL cause a release.

Reset
REQ-031 On rstn low, asynchronously: state=IDLE, gnt=0, owner=0, rr_ptr=0, burst_cnt=0, busy=0.
REQ-032 During reset, req_ack=0 and fifo_wr_en=0 (follows from gnt=0).
REQ-033 Reset asserted mid-burst SHALL drop the grant immediately with no partial-state retention; after rstn rises, arbitration SHALL restart from rr_ptr=0.

Verification
REQ-034 Scenario: NREQ=4, MAX_BURST=4, req=4'b0101 held, fifo_full=0 -> gnt=0001 after 1 cycle, 4 acks from req0; then gnt=0100 with no bubble, 4 acks; then gnt=0001 again.
REQ-035 Scenario: req0 only, drops req after 2 words -> 2 writes with fifo_data=req0 data; IDLE next cycle; rr_ptr=1.
REQ-036 Scenario: owner req2 with fifo_full=1 for 3 cycles mid-burst -> fifo_wr_en=0, gnt stays 0100, burst_cnt held; burst resumes and completes at 4 total words.
REQ-037 Scenario: all 4 req high continuously -> grant order 0,1,2,3,0, each burst exactly 4 words, 16 writes per 16 unstalled cycles after first grant.
REQ-038 Scenario: rstn pulsed low during word 2 of req1's burst -> gnt=0 and fifo_wr_en=0 immediately; after release with req=1111, first grant goes to req0.
REQ-039 Scenario: MAX_BURST=1, req=0011 -> one word each, alternating 0,1,0,1 every cycle.
